// File: rtl/serializer_pkg.sv
// Shared definitions for the byte serializer: frame states and line constants.
package serializer_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } serState_t;

  localparam int   DATA_BITS  = 8;
  localparam logic IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with show-ahead output; head word is visible on dout while not empty.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wrPtr;
  logic [PTR_W-1:0] r_rdPtr;
  logic [CNT_W-1:0] r_count;
  logic             w_doPush;
  logic             w_doPop;

  assign w_doPush = push && !full;
  assign w_doPop  = pop && !empty;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_doPush) r_wrPtr <= r_wrPtr + PTR_W'(1);
      if (w_doPop)  r_rdPtr <= r_rdPtr + PTR_W'(1);
      case ({w_doPush, w_doPop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_doPush) r_mem[r_wrPtr] <= din;
  end

  assign dout  = r_mem[r_rdPtr];
  assign full  = (r_count == CNT_W'(DEPTH));
  assign empty = (r_count == '0);

endmodule

// File: rtl/byte_serializer.sv
// Byte-to-serial framer: start bit, 8 data bits LSB first, optional even parity, stop bit,
// each bit held DIV cycles, fed from a small input FIFO.
module byte_serializer
  import serializer_pkg::*;
#(
  parameter int DIV       = 4,
  parameter int PARITY_EN = 0,
  parameter int DEPTH     = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output logic       sd,
  output logic       busy,
  output logic       frame_done
);

  localparam logic [7:0] RELOAD   = 8'(DIV - 1);
  localparam logic [2:0] LAST_IDX = 3'(DATA_BITS - 1);

  serState_t  r_state;
  logic [7:0] r_shift;
  logic [7:0] r_bitTimer;
  logic [2:0] r_bitIdx;
  logic       r_parity;
  logic       r_sd;
  logic       r_frameDone;

  logic       w_full;
  logic       w_empty;
  logic [7:0] w_head;
  logic       w_push;
  logic       w_pop;
  logic       w_bitEnd;

  // in_ready ignores pops so a full FIFO never takes a byte, and drops during reset.
  assign in_ready = !w_full && !rst;
  assign w_push   = in_valid && in_ready;
  assign w_bitEnd = (r_bitTimer == 8'd0);
  assign w_pop    = !rst && !w_empty &&
                    ((r_state == IDLE) || ((r_state == STOP) && w_bitEnd));

  sync_fifo #(
    .WIDTH(8),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (w_push),
    .pop  (w_pop),
    .din  (in_data),
    .dout (w_head),
    .full (w_full),
    .empty(w_empty)
  );

  // Frame sequencer; sd and frame_done are set on the edge that enters the cycle they describe.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_shift     <= 8'd0;
      r_bitTimer  <= 8'd0;
      r_bitIdx    <= 3'd0;
      r_parity    <= 1'b0;
      r_sd        <= IDLE_LEVEL;
      r_frameDone <= 1'b0;
    end else begin
      r_frameDone <= 1'b0;
      if ((r_state != IDLE) && !w_bitEnd) begin
        r_bitTimer <= r_bitTimer - 8'd1;
      end
      if ((r_state == STOP) && (r_bitTimer == 8'd1)) begin
        r_frameDone <= 1'b1;
      end
      case (r_state)
        IDLE: begin
          if (!w_empty) begin
            r_shift    <= w_head;
            r_parity   <= ^w_head;
            r_state    <= START;
            r_sd       <= 1'b0;
            r_bitTimer <= RELOAD;
          end
        end
        START: begin
          if (w_bitEnd) begin
            r_state    <= DATA;
            r_sd       <= r_shift[0];
            r_bitIdx   <= 3'd0;
            r_bitTimer <= RELOAD;
          end
        end
        DATA: begin
          if (w_bitEnd) begin
            r_bitTimer <= RELOAD;
            if (r_bitIdx == LAST_IDX) begin
              if (PARITY_EN != 0) begin
                r_state <= PARITY;
                r_sd    <= r_parity;
              end else begin
                r_state     <= STOP;
                r_sd        <= IDLE_LEVEL;
                r_frameDone <= (DIV == 1);
              end
            end else begin
              r_shift  <= r_shift >> 1;
              r_sd     <= r_shift[1];
              r_bitIdx <= r_bitIdx + 3'd1;
            end
          end
        end
        PARITY: begin
          if (w_bitEnd) begin
            r_state     <= STOP;
            r_sd        <= IDLE_LEVEL;
            r_bitTimer  <= RELOAD;
            r_frameDone <= (DIV == 1);
          end
        end
        STOP: begin
          if (w_bitEnd) begin
            r_bitTimer <= RELOAD;
            if (!w_empty) begin
              r_shift  <= w_head;
              r_parity <= ^w_head;
              r_state  <= START;
              r_sd     <= 1'b0;
            end else begin
              r_state <= IDLE;
              r_sd    <= IDLE_LEVEL;
            end
          end
        end
        default: begin
          r_state <= IDLE;
          r_sd    <= IDLE_LEVEL;
        end
      endcase
    end
  end

  assign sd         = r_sd;
  assign frame_done = r_frameDone;
  assign busy       = (r_state != IDLE) || !w_empty;

endmodule

// File: tb/tb_byte_serializer.sv
// Bench for byte_serializer: three configurations driven by directed bytes, with a
// scoreboard queue and a per-instance frame monitor comparing captured sd waveforms.
module tb_byte_serializer;

  typedef struct {
    int         dut;
    logic [7:0] data;
  } expItem_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] inData = 8'd0;
  logic [2:0] inValid = 3'b000;
  logic [2:0] inReady;
  logic [2:0] sdV;
  logic [2:0] busyV;
  logic [2:0] doneV;

  expItem_t   expQ[$];
  int         checks = 0;
  int         failures = 0;

  bit   [2:0]  capturing = 3'b000;
  int          cyc[3];
  logic [63:0] samp[3];
  logic [63:0] doneBits[3];

  always #5 clk = ~clk;

  byte_serializer #(.DIV(4), .PARITY_EN(0), .DEPTH(4)) u_dutBase (
    .clk(clk), .rst(rst), .in_valid(inValid[0]), .in_data(inData),
    .in_ready(inReady[0]), .sd(sdV[0]), .busy(busyV[0]), .frame_done(doneV[0])
  );

  byte_serializer #(.DIV(4), .PARITY_EN(1), .DEPTH(4)) u_dutPar (
    .clk(clk), .rst(rst), .in_valid(inValid[1]), .in_data(inData),
    .in_ready(inReady[1]), .sd(sdV[1]), .busy(busyV[1]), .frame_done(doneV[1])
  );

  byte_serializer #(.DIV(1), .PARITY_EN(0), .DEPTH(4)) u_dutDiv1 (
    .clk(clk), .rst(rst), .in_valid(inValid[2]), .in_data(inData),
    .in_ready(inReady[2]), .sd(sdV[2]), .busy(busyV[2]), .frame_done(doneV[2])
  );

  function automatic int divOf(input int k);
    return (k == 2) ? 1 : 4;
  endfunction

  function automatic int parOf(input int k);
    return (k == 1) ? 1 : 0;
  endfunction

  function automatic int frameLen(input int k);
    return (10 + parOf(k)) * divOf(k);
  endfunction

  // Reference line waveform: start, data LSB first, optional even parity, stop.
  function automatic logic [63:0] frameWave(input logic [7:0] d, input int div, input int par);
    logic [10:0] bits;
    logic [63:0] w;
    int n;
    bits = '0;
    w = '0;
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[i+1] = d[i];
    n = 9;
    if (par != 0) begin
      bits[9] = ^d;
      n = 10;
    end
    bits[n] = 1'b1;
    n = n + 1;
    for (int b = 0; b < n; b++)
      for (int j = 0; j < div; j++) w[b*div+j] = bits[b];
    return w;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  // Call at a negedge; presents one byte for one cycle and records it if accepted.
  task automatic applyStimulus(input int k, input logic [7:0] d);
    expItem_t it;
    inValid[k] = 1'b1;
    inData = d;
    if (inReady[k]) begin
      it.dut = k;
      it.data = d;
      expQ.push_back(it);
    end
    @(negedge clk);
    inValid[k] = 1'b0;
  endtask

  task automatic waitIdle(input int k);
    int n;
    n = 0;
    while ((busyV[k] || capturing[k]) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    checkOutput("idle timeout", 64'(n < 3000), 64'd1);
    checkOutput("queue drained", 64'(expQ.size()), 64'd0);
  endtask

  task automatic waitStart(input int k);
    int n;
    n = 0;
    while (sdV[k] != 1'b0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    checkOutput("start timeout", 64'(n < 200), 64'd1);
  endtask

  // Monitor: captures each frame from its start bit and checks it against the scoreboard.
  initial begin
    expItem_t it;
    forever begin
      @(negedge clk);
      if (rst) expQ.delete();
      for (int k = 0; k < 3; k++) begin
        if (rst) begin
          capturing[k] = 1'b0;
        end else begin
          if (!capturing[k] && doneV[k]) begin
            checks++;
            failures++;
            $display("[TB] FAIL stray frame_done dut%0d: got 1 expected 0", k);
          end
          if (!capturing[k] && sdV[k] == 1'b0) begin
            capturing[k] = 1'b1;
            cyc[k] = 0;
            samp[k] = '0;
            doneBits[k] = '0;
          end
          if (capturing[k]) begin
            samp[k][cyc[k]] = sdV[k];
            doneBits[k][cyc[k]] = doneV[k];
            cyc[k]++;
            if (cyc[k] == frameLen(k)) begin
              capturing[k] = 1'b0;
              if (expQ.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL unexpected frame dut%0d: got frame expected none", k);
              end else begin
                it = expQ.pop_front();
                checkOutput("frame owner", 64'(it.dut), 64'(k));
                checkOutput("frame wave", samp[k], frameWave(it.data, divOf(k), parOf(k)));
                checkOutput("frame_done pos", doneBits[k], 64'd1 << (frameLen(k) - 1));
              end
            end
          end
        end
      end
    end
  end

  initial begin
    #500000;
    failures++;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    int busyCnt;
    int accepted;
    int n;
    int lowCnt;
    logic heldLow;

    // Reset state on every instance.
    repeat (2) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      checkOutput("reset sd", 64'(sdV[k]), 64'd1);
      checkOutput("reset busy", 64'(busyV[k]), 64'd0);
      checkOutput("reset frame_done", 64'(doneV[k]), 64'd0);
      checkOutput("reset in_ready", 64'(inReady[k]), 64'd0);
    end
    rst = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 3; k++) checkOutput("ready after reset", 64'(inReady[k]), 64'd1);

    // Single byte with one-cycle latency to the start bit.
    applyStimulus(0, 8'hA5);
    checkOutput("latency idle", 64'(sdV[0]), 64'd1);
    @(negedge clk);
    checkOutput("latency start", 64'(sdV[0]), 64'd0);
    waitIdle(0);

    // Back-to-back bytes: no idle gap, busy across both frames.
    applyStimulus(0, 8'h00);
    applyStimulus(0, 8'hFF);
    waitStart(0);
    busyCnt = 0;
    for (int i = 0; i < 80; i++) begin
      if (busyV[0]) busyCnt++;
      if (i == 40) checkOutput("b2b gap", 64'(sdV[0]), 64'd0);
      @(negedge clk);
    end
    checkOutput("busy span", 64'(busyCnt), 64'd80);
    checkOutput("busy drop", 64'(busyV[0]), 64'd0);
    waitIdle(0);

    // FIFO full: 8 offered cycles, 5 accepted, ready low until the first pop.
    accepted = 0;
    for (int i = 0; i < 8; i++) begin
      expItem_t it;
      inValid[0] = 1'b1;
      inData = 8'((i + 1) * 17);
      if (inReady[0]) begin
        accepted++;
        it.dut = 0;
        it.data = inData;
        expQ.push_back(it);
      end
      @(negedge clk);
    end
    inValid[0] = 1'b0;
    checkOutput("accepted count", 64'(accepted), 64'd5);
    checkOutput("full in_ready", 64'(inReady[0]), 64'd0);
    n = 0;
    heldLow = 1'b1;
    while (!doneV[0] && n < 100) begin
      if (inReady[0]) heldLow = 1'b0;
      @(negedge clk);
      n++;
    end
    checkOutput("ready held low", 64'(heldLow), 64'd1);
    checkOutput("frame_done timeout", 64'(n < 100), 64'd1);
    @(negedge clk);
    checkOutput("ready after pop", 64'(inReady[0]), 64'd1);
    waitIdle(0);

    // Even parity frames.
    applyStimulus(1, 8'h07);
    waitIdle(1);
    applyStimulus(1, 8'h03);
    waitIdle(1);

    // Reset during data bit 3 with two bytes queued.
    applyStimulus(0, 8'h3C);
    applyStimulus(0, 8'h5A);
    applyStimulus(0, 8'h96);
    waitStart(0);
    repeat (17) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("midreset sd", 64'(sdV[0]), 64'd1);
    checkOutput("midreset busy", 64'(busyV[0]), 64'd0);
    checkOutput("midreset in_ready", 64'(inReady[0]), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("ready after midreset", 64'(inReady[0]), 64'd1);
    lowCnt = 0;
    for (int i = 0; i < 100; i++) begin
      if (sdV[0] == 1'b0) lowCnt++;
      @(negedge clk);
    end
    checkOutput("no frame after reset", 64'(lowCnt), 64'd0);
    checkOutput("idle after reset", 64'(busyV[0]), 64'd0);

    // One cycle per bit.
    applyStimulus(2, 8'h5A);
    waitIdle(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
